// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer
//   Command front-end for the ALU top level. Commands (A, B, FUNC) are buffered
//   in a FIFO behind a valid/ready handshake. They are issued one at a time to
//   the ALU. The registered result of the enabled unit is captured one cycle
//   later, zero-extended, and held on a valid/ready result port.
//
// Ports
//   CLK, RST                      clock, asynchronous active-high reset
//   CMD_VALID/CMD_READY           command handshake; CMD_A, CMD_B, CMD_FUNC payload
//   ALU_A/ALU_B/ALU_FUNC          registered drive to the ALU
//   Arith_OUT..CMP_Flag           ALU unit results and per-unit flags
//   RES_VALID/RES_READY           result handshake; RES_DATA, RES_CARRY, RES_FUNC payload
//   ERR                           sticky flag-check error
//
// Configuration
//   ALU_SEQ_FLAG_CHECK_EN: when defined, each capture checks that only the
//   selected unit's flag is set, and sets ERR on any violation. When it is
//   undefined, ERR is tied low and the flag inputs are ignored.
module alu_cmd_sequencer #(
  parameter int unsigned OP_DATA_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned RES_WIDTH     = 2 * OP_DATA_WIDTH
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     CMD_VALID,
  output logic                     CMD_READY,
  input  logic [OP_DATA_WIDTH-1:0] CMD_A,
  input  logic [OP_DATA_WIDTH-1:0] CMD_B,
  input  logic [3:0]               CMD_FUNC,
  output logic [OP_DATA_WIDTH-1:0] ALU_A,
  output logic [OP_DATA_WIDTH-1:0] ALU_B,
  output logic [3:0]               ALU_FUNC,
  input  logic [RES_WIDTH-1:0]     Arith_OUT,
  input  logic                     Carry_OUT,
  input  logic                     Arith_Flag,
  input  logic [OP_DATA_WIDTH-1:0] Logic_OUT,
  input  logic                     Logic_Flag,
  input  logic [OP_DATA_WIDTH-1:0] Shift_OUT,
  input  logic                     Shift_Flag,
  input  logic [2:0]               CMP_OUT,
  input  logic                     CMP_Flag,
  output logic                     RES_VALID,
  input  logic                     RES_READY,
  output logic [RES_WIDTH-1:0]     RES_DATA,
  output logic                     RES_CARRY,
  output logic [3:0]               RES_FUNC,
  output logic                     ERR
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_OUTPUT  = 2'd3;

  localparam logic [1:0] G_ARITH = 2'b00;
  localparam logic [1:0] G_LOGIC = 2'b01;
  localparam logic [1:0] G_CMP   = 2'b10;
  localparam logic [1:0] G_SHIFT = 2'b11;

  typedef struct packed {
    logic [OP_DATA_WIDTH-1:0] a;
    logic [OP_DATA_WIDTH-1:0] b;
    logic [3:0]               func;
  } cmd_t;

  logic [1:0]           state_q, state_d;
  cmd_t                 mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic                 fifo_full, fifo_empty;
  logic                 push_c, pop_c, capture_c, res_take_c;
  cmd_t                 head_c;
  logic [RES_WIDTH-1:0] sel_data_c;
  logic                 sel_carry_c;

  logic [OP_DATA_WIDTH-1:0] alu_a_q, alu_b_q;
  logic [3:0]               alu_func_q;
  logic                     res_valid_q, res_carry_q;
  logic [RES_WIDTH-1:0]     res_data_q;
  logic [3:0]               res_func_q;

  // FIFO status and handshakes; pops only from IDLE, so a push is never bypassed
  assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign CMD_READY  = !fifo_full && !RST;
  assign push_c     = CMD_VALID && CMD_READY;
  assign pop_c      = (state_q == S_IDLE) && !fifo_empty;
  assign capture_c  = (state_q == S_CAPTURE);
  assign res_take_c = (state_q == S_OUTPUT) && RES_READY;
  assign head_c     = mem[rd_ptr_q];

  // FIFO storage: entries are only read after being written, so no reset needed
  always_ff @(posedge CLK) begin
    if (push_c) begin
      mem[wr_ptr_q] <= '{a: CMD_A, b: CMD_B, func: CMD_FUNC};
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_c) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_c, pop_c})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // State register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (!fifo_empty) state_d = S_ISSUE;
      S_ISSUE:   state_d = S_CAPTURE;
      S_CAPTURE: state_d = S_OUTPUT;
      S_OUTPUT:  if (RES_READY) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Result select by function group; carry is meaningful only for arith
  always_comb begin
    sel_data_c  = '0;
    sel_carry_c = 1'b0;
    case (alu_func_q[3:2])
      G_ARITH: begin
        sel_data_c  = Arith_OUT;
        sel_carry_c = Carry_OUT;
      end
      G_LOGIC: sel_data_c = RES_WIDTH'(Logic_OUT);
      G_CMP:   sel_data_c = RES_WIDTH'(CMP_OUT);
      G_SHIFT: sel_data_c = RES_WIDTH'(Shift_OUT);
      default: sel_data_c = '0;
    endcase
  end

  // ALU drive and result registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_func_q  <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_carry_q <= 1'b0;
      res_func_q  <= '0;
    end else begin
      if (pop_c) begin
        alu_a_q    <= head_c.a;
        alu_b_q    <= head_c.b;
        alu_func_q <= head_c.func;
      end
      if (capture_c) begin
        res_valid_q <= 1'b1;
        res_data_q  <= sel_data_c;
        res_carry_q <= sel_carry_c;
        res_func_q  <= alu_func_q;
      end else if (res_take_c) begin
        res_valid_q <= 1'b0;
      end
    end
  end

`ifdef ALU_SEQ_FLAG_CHECK_EN
  logic [3:0] flags_c;
  logic [3:0] flags_exp_c;
  logic       err_q;

  // Flag vector indexed by group: bit0 arith, bit1 logic, bit2 cmp, bit3 shift
  assign flags_c     = {Shift_Flag, CMP_Flag, Logic_Flag, Arith_Flag};
  assign flags_exp_c = 4'b0001 << alu_func_q[3:2];

  // Sticky error: only the selected unit's flag may be high at capture
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                                       err_q <= 1'b0;
    else if (capture_c && (flags_c != flags_exp_c)) err_q <= 1'b1;
  end

  assign ERR = err_q;
`else
  logic unused_flags;
  assign unused_flags = ^{Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag};
  assign ERR = 1'b0;
`endif

  assign ALU_A     = alu_a_q;
  assign ALU_B     = alu_b_q;
  assign ALU_FUNC  = alu_func_q;
  assign RES_VALID = res_valid_q;
  assign RES_DATA  = res_data_q;
  assign RES_CARRY = res_carry_q;
  assign RES_FUNC  = res_func_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed self-checking bench for alu_cmd_sequencer with a registered ALU stub.
module tb_alu_cmd_sequencer;

  logic        CLK, RST;
  logic        CMD_VALID, CMD_READY;
  logic [15:0] CMD_A, CMD_B;
  logic [3:0]  CMD_FUNC;
  logic [15:0] ALU_A, ALU_B;
  logic [3:0]  ALU_FUNC;
  logic [31:0] Arith_OUT;
  logic        Carry_OUT, Arith_Flag;
  logic [15:0] Logic_OUT;
  logic        Logic_Flag;
  logic [15:0] Shift_OUT;
  logic        Shift_Flag;
  logic [2:0]  CMP_OUT;
  logic        CMP_Flag;
  logic        RES_VALID, RES_READY;
  logic [31:0] RES_DATA;
  logic        RES_CARRY;
  logic [3:0]  RES_FUNC;
  logic        ERR;

  int checks;
  int failures;
  logic force_logic_flag;
  logic logic_flag_q;

  alu_cmd_sequencer dut (
    .CLK(CLK), .RST(RST),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_A(CMD_A), .CMD_B(CMD_B), .CMD_FUNC(CMD_FUNC),
    .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUNC(ALU_FUNC),
    .Arith_OUT(Arith_OUT), .Carry_OUT(Carry_OUT), .Arith_Flag(Arith_Flag),
    .Logic_OUT(Logic_OUT), .Logic_Flag(Logic_Flag),
    .Shift_OUT(Shift_OUT), .Shift_Flag(Shift_Flag),
    .CMP_OUT(CMP_OUT), .CMP_Flag(CMP_Flag),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY),
    .RES_DATA(RES_DATA), .RES_CARRY(RES_CARRY), .RES_FUNC(RES_FUNC),
    .ERR(ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign Logic_Flag = logic_flag_q | force_logic_flag;

  // Registered ALU stub. Units that are not selected drive junk values, so a
  // wrong group select or an ungated carry shows up in the result.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      Arith_OUT <= '0; Carry_OUT <= 1'b0; Logic_OUT <= '0; Shift_OUT <= '0;
      CMP_OUT <= '0; Arith_Flag <= 1'b0; logic_flag_q <= 1'b0;
      CMP_Flag <= 1'b0; Shift_Flag <= 1'b0;
    end else begin
      Arith_OUT <= 32'hDEAD_BEEF; Carry_OUT <= 1'b1;
      Logic_OUT <= 16'hA5A5; Shift_OUT <= 16'h5A5A; CMP_OUT <= 3'b111;
      Arith_Flag <= 1'b0; logic_flag_q <= 1'b0; CMP_Flag <= 1'b0; Shift_Flag <= 1'b0;
      case (ALU_FUNC[3:2])
        2'b00: begin
          Arith_Flag <= 1'b1;
          case (ALU_FUNC[1:0])
            2'b00: begin
              Arith_OUT <= 32'(ALU_A) + 32'(ALU_B);
              Carry_OUT <= ((17'(ALU_A) + 17'(ALU_B)) >> 16) != 17'd0;
            end
            2'b01: begin
              Arith_OUT <= 32'(ALU_A - ALU_B);
              Carry_OUT <= (ALU_A < ALU_B);
            end
            2'b10: begin
              Arith_OUT <= 32'(ALU_A) * 32'(ALU_B);
              Carry_OUT <= 1'b0;
            end
            default: begin
              Arith_OUT <= (ALU_B != 16'd0) ? 32'(ALU_A / ALU_B) : 32'd0;
              Carry_OUT <= 1'b0;
            end
          endcase
        end
        2'b01: begin
          logic_flag_q <= 1'b1;
          case (ALU_FUNC[1:0])
            2'b00:   Logic_OUT <= ALU_A & ALU_B;
            2'b01:   Logic_OUT <= ALU_A | ALU_B;
            2'b10:   Logic_OUT <= ~(ALU_A & ALU_B);
            default: Logic_OUT <= ~(ALU_A | ALU_B);
          endcase
        end
        2'b10: begin
          CMP_Flag <= 1'b1;
          CMP_OUT  <= {ALU_A > ALU_B, ALU_A == ALU_B, ALU_A < ALU_B};
        end
        default: begin
          Shift_Flag <= 1'b1;
          case (ALU_FUNC[1:0])
            2'b00:   Shift_OUT <= ALU_A >> 1;
            2'b01:   Shift_OUT <= ALU_A << 1;
            2'b10:   Shift_OUT <= ALU_B >> 1;
            default: Shift_OUT <= ALU_B << 1;
          endcase
        end
      endcase
    end
  end

  // Offer one command from a negedge; returns at the negedge after acceptance.
  task automatic push(input logic [15:0] a, input logic [15:0] b,
                      input logic [3:0] f, output bit ok);
    logic rdy;
    CMD_A = a; CMD_B = b; CMD_FUNC = f; CMD_VALID = 1'b1; ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      rdy = CMD_READY;
      @(negedge CLK);
      if (rdy) begin ok = 1'b1; break; end
    end
    CMD_VALID = 1'b0;
  endtask

  // Take one result with RES_READY high; lat counts negedges waited for RES_VALID.
  task automatic get_result(output logic [31:0] d, output logic c, output logic [3:0] f,
                            output int lat, output bit ok);
    RES_READY = 1'b1; ok = 1'b0; lat = 0; d = '0; c = 1'b0; f = '0;
    for (int i = 0; i < 60; i++) begin
      if (RES_VALID) begin
        d = RES_DATA; c = RES_CARRY; f = RES_FUNC; ok = 1'b1;
        @(negedge CLK);
        break;
      end
      @(negedge CLK);
      lat++;
    end
    RES_READY = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    checks++;
    if (CMD_READY !== 1'b0) begin failures++; $display("FAIL reset_cmd_ready_in_rst got=%b exp=0", CMD_READY); end
    checks++;
    if (RES_VALID !== 1'b0) begin failures++; $display("FAIL reset_res_valid got=%b exp=0", RES_VALID); end
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (CMD_READY !== 1'b1) begin failures++; $display("FAIL reset_cmd_ready_after got=%b exp=1", CMD_READY); end
    checks++;
    if ({ALU_A, ALU_B, ALU_FUNC} !== 36'd0) begin failures++; $display("FAIL reset_alu_inputs got=%h exp=0", {ALU_A, ALU_B, ALU_FUNC}); end
    checks++;
    if (RES_DATA !== 32'd0) begin failures++; $display("FAIL reset_res_data got=%h exp=0", RES_DATA); end
    checks++;
    if ({RES_CARRY, RES_FUNC, ERR} !== 6'd0) begin failures++; $display("FAIL reset_res_misc got=%b exp=0", {RES_CARRY, RES_FUNC, ERR}); end
  endtask

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  f;
    logic [31:0] d;
    logic        c;
  } vec_t;

  task automatic test_alu_ops();
    vec_t v [9];
    logic [31:0] d; logic c; logic [3:0] f; int lat; bit ok;
    v[0] = '{a: 16'h0003, b: 16'h0004, f: 4'b0000, d: 32'h0000_0007, c: 1'b0};
    v[1] = '{a: 16'hFFFF, b: 16'h0001, f: 4'b0000, d: 32'h0001_0000, c: 1'b1};
    v[2] = '{a: 16'h000A, b: 16'h0003, f: 4'b0001, d: 32'h0000_0007, c: 1'b0};
    v[3] = '{a: 16'hFFFF, b: 16'hFFFF, f: 4'b0010, d: 32'hFFFE_0001, c: 1'b0};
    v[4] = '{a: 16'hF0F0, b: 16'hFF00, f: 4'b0100, d: 32'h0000_F000, c: 1'b0};
    v[5] = '{a: 16'h0005, b: 16'h0009, f: 4'b1000, d: 32'h0000_0001, c: 1'b0};
    v[6] = '{a: 16'h8001, b: 16'h0000, f: 4'b1101, d: 32'h0000_0002, c: 1'b0};
    v[7] = '{a: 16'h0064, b: 16'h0007, f: 4'b0011, d: 32'h0000_000E, c: 1'b0};
    v[8] = '{a: 16'h0F0F, b: 16'h00FF, f: 4'b0111, d: 32'h0000_F000, c: 1'b0};
    for (int i = 0; i < 9; i++) begin
      push(v[i].a, v[i].b, v[i].f, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL ops_push_timeout vec=%0d", i); end
      get_result(d, c, f, lat, ok);
      checks++;
      if (!ok || lat != 3) begin failures++; $display("FAIL ops_latency vec=%0d got=%0d ok=%0d exp=3", i, lat, ok); end
      checks++;
      if (d !== v[i].d) begin failures++; $display("FAIL ops_data vec=%0d got=%h exp=%h", i, d, v[i].d); end
      checks++;
      if (c !== v[i].c || f !== v[i].f) begin
        failures++; $display("FAIL ops_carry_func vec=%0d got=%b/%b exp=%b/%b", i, c, f, v[i].c, v[i].f);
      end
    end
    checks++;
    if (ERR !== 1'b0) begin failures++; $display("FAIL ops_err got=%b exp=0", ERR); end
  endtask

  task automatic test_full_fifo();
    logic [31:0] d; logic c; logic [3:0] f; int lat; bit ok; bit rdy_seen;
    RES_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(16'h0100 + 16'(i), 16'h0010, 4'b0000, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL full_push_timeout idx=%0d", i); end
    end
    checks++;
    if (CMD_READY !== 1'b0) begin failures++; $display("FAIL full_cmd_ready got=%b exp=0", CMD_READY); end
    // Sixth command is offered but must not be accepted while the result stalls
    CMD_A = 16'h0999; CMD_B = 16'h0001; CMD_FUNC = 4'b0000; CMD_VALID = 1'b1;
    rdy_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (CMD_READY) rdy_seen = 1'b1;
      @(negedge CLK);
    end
    CMD_VALID = 1'b0;
    checks++;
    if (rdy_seen) begin failures++; $display("FAIL full_sixth_blocked got=1 exp=0"); end
    for (int i = 0; i < 5; i++) begin
      get_result(d, c, f, lat, ok);
      checks++;
      if (!ok || d !== 32'h0000_0110 + 32'(i)) begin
        failures++; $display("FAIL full_order idx=%0d got=%h ok=%0d exp=%h", i, d, ok, 32'h0000_0110 + 32'(i));
      end
      if (i > 0) begin
        checks++;
        if (lat != 3) begin failures++; $display("FAIL full_throughput idx=%0d got=%0d exp=3", i, lat); end
      end
    end
    repeat (6) @(negedge CLK);
    checks++;
    if (RES_VALID !== 1'b0) begin failures++; $display("FAIL full_no_extra got=%b exp=0", RES_VALID); end
  endtask

  task automatic test_backpressure();
    logic [31:0] d0; bit ok; bit stable;
    RES_READY = 1'b0;
    push(16'h1234, 16'h1111, 4'b0000, ok);
    for (int i = 0; i < 20 && !RES_VALID; i++) @(negedge CLK);
    checks++;
    if (!ok || RES_VALID !== 1'b1) begin failures++; $display("FAIL bp_valid_timeout got=%b exp=1", RES_VALID); end
    d0 = RES_DATA;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (RES_VALID !== 1'b1 || RES_DATA !== d0) stable = 1'b0;
    end
    checks++;
    if (!stable || d0 !== 32'h0000_2345) begin failures++; $display("FAIL bp_stable got=%h stable=%0d exp=00002345", d0, stable); end
    RES_READY = 1'b1;
    @(negedge CLK);
    RES_READY = 1'b0;
    checks++;
    if (RES_VALID !== 1'b0) begin failures++; $display("FAIL bp_handshake got=%b exp=0", RES_VALID); end
  endtask

  task automatic test_reset_mid();
    bit ok; bit stale;
    RES_READY = 1'b0;
    push(16'h0001, 16'h0001, 4'b0000, ok);
    for (int i = 0; i < 20 && !RES_VALID; i++) @(negedge CLK);
    push(16'h0022, 16'h0001, 4'b0000, ok);
    push(16'h0033, 16'h0001, 4'b0000, ok);
    push(16'h0044, 16'h0001, 4'b0000, ok);
    checks++;
    if (!ok || RES_VALID !== 1'b1) begin failures++; $display("FAIL rmid_setup got=%b exp=1", RES_VALID); end
    RES_READY = 1'b1;
    @(negedge CLK);           // result taken, back to IDLE
    RES_READY = 1'b0;
    @(negedge CLK);           // head popped, now ISSUE with two queued
    checks++;
    if (ALU_A !== 16'h0022) begin failures++; $display("FAIL rmid_issue got=%h exp=0022", ALU_A); end
    RST = 1'b1;
    #1;
    checks++;
    if (RES_VALID !== 1'b0 || CMD_READY !== 1'b0) begin
      failures++; $display("FAIL rmid_immediate got=%b%b exp=00", RES_VALID, CMD_READY);
    end
    checks++;
    if (ALU_A !== 16'h0000 || RES_DATA !== 32'd0) begin
      failures++; $display("FAIL rmid_outputs got=%h/%h exp=0/0", ALU_A, RES_DATA);
    end
    @(negedge CLK);
    RST = 1'b0;
    RES_READY = 1'b1;
    stale = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (RES_VALID !== 1'b0 || ALU_A !== 16'h0000) stale = 1'b1;
    end
    RES_READY = 1'b0;
    checks++;
    if (stale) begin failures++; $display("FAIL rmid_stale got=1 exp=0"); end
    checks++;
    if (CMD_READY !== 1'b1) begin failures++; $display("FAIL rmid_ready_after got=%b exp=1", CMD_READY); end
  endtask

  task automatic test_flag_check();
    logic [31:0] d; logic c; logic [3:0] f; int lat; bit ok;
    force_logic_flag = 1'b1;
    push(16'h0002, 16'h0005, 4'b0000, ok);
    get_result(d, c, f, lat, ok);
    force_logic_flag = 1'b0;
    checks++;
    if (!ok || d !== 32'h0000_0007) begin failures++; $display("FAIL flag_result got=%h exp=00000007", d); end
`ifdef ALU_SEQ_FLAG_CHECK_EN
    checks++;
    if (ERR !== 1'b1) begin failures++; $display("FAIL flag_err_set got=%b exp=1", ERR); end
    push(16'h0001, 16'h0001, 4'b0100, ok);
    get_result(d, c, f, lat, ok);
    checks++;
    if (ERR !== 1'b1) begin failures++; $display("FAIL flag_err_sticky got=%b exp=1", ERR); end
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    @(negedge CLK);
    checks++;
    if (ERR !== 1'b0) begin failures++; $display("FAIL flag_err_cleared got=%b exp=0", ERR); end
`else
    checks++;
    if (ERR !== 1'b0) begin failures++; $display("FAIL flag_err_disabled got=%b exp=0", ERR); end
`endif
  endtask

  initial begin
    checks = 0; failures = 0;
    RST = 1'b1; CMD_VALID = 1'b0; CMD_A = '0; CMD_B = '0; CMD_FUNC = '0;
    RES_READY = 1'b0; force_logic_flag = 1'b0;
    @(negedge CLK);
    test_reset();
    test_alu_ops();
    test_full_fifo();
    test_backpressure();
    test_reset_mid();
    test_flag_check();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_cmd_sequencer.md
# alu_cmd_sequencer

Command front-end for the ALU top level. It buffers operand/function commands in a small FIFO behind a valid/ready handshake and issues them one at a time to the ALU's A/B/ALU_FUNC inputs. It captures the registered result of the enabled unit one cycle later, zero-extends it to a single result word, and holds that word on a valid/ready output until a consumer takes it.

## Interface
- OP_DATA_WIDTH, 16, operand width; equals the ALU's OP_DATA_WIDTH.
- FIFO_DEPTH, 4, number of command entries; power of 2, minimum 2.
- RES_WIDTH, 2*OP_DATA_WIDTH, result word width; equals the ALU's Arith_OUT width.
- Clock and reset: one clock; reset is asynchronous and active-high.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  FIFO can accept a command.
- CMD_A  in  OP_DATA_WIDTH  operand A.
- CMD_B  in  OP_DATA_WIDTH  operand B.
- CMD_FUNC  in  4  ALU function code.
- ALU_A  out  OP_DATA_WIDTH  to ALU A; registered.
- ALU_B  out  OP_DATA_WIDTH  to ALU B; registered.
- ALU_FUNC  out  4  to ALU ALU_FUNC; registered.
- Arith_OUT  in  RES_WIDTH  ALU arithmetic result.
- Carry_OUT  in  1  ALU carry out.
- Arith_Flag  in  1  ALU arithmetic-unit flag.
- Logic_OUT  in  OP_DATA_WIDTH  ALU logic result.
- Logic_Flag  in  1  ALU logic-unit flag.
- Shift_OUT  in  OP_DATA_WIDTH  ALU shift result.
- Shift_Flag  in  1  ALU shift-unit flag.
- CMP_OUT  in  3  ALU compare result.
- CMP_Flag  in  1  ALU compare-unit flag.
- RES_VALID  out  1  result word valid.
- RES_READY  in  1  consumer accepts the result.
- RES_DATA  out  RES_WIDTH  captured result, zero-extended.
- RES_CARRY  out  1  captured Carry_OUT; 0 for non-arithmetic groups.
- RES_FUNC  out  4  function code that produced RES_DATA.
- ERR  out  1  sticky flag-check error; see Configuration.

## Operation
- Function group is ALU_FUNC[3:2]:
  - 00 arith, ALU_FUNC[1:0] = add, sub, mul, div.
  - 01 logic, ALU_FUNC[1:0] = AND, OR, NAND, NOR.
  - 10 compare.
  - 11 shift.
- FIFO push: a command is pushed when CMD_VALID && CMD_READY.
- CMD_READY = !full && !RST.
- Occupancy counter runs 0..FIFO_DEPTH. Read and write pointers wrap modulo FIFO_DEPTH.
- No bypass: a command pushed into an empty FIFO is popped no earlier than the next cycle.
- A simultaneous push and pop leaves the count unchanged.
- State machine: IDLE -> ISSUE -> CAPTURE -> OUTPUT -> IDLE.
  - IDLE: if the FIFO is not empty, pop the head into ALU_A/ALU_B/ALU_FUNC and go to ISSUE.
  - ISSUE: hold the ALU inputs for one cycle while the ALU registers its result. Go to CAPTURE.
  - CAPTURE: select the result by group and load RES_DATA, RES_CARRY and RES_FUNC.
    - arith: RES_DATA = Arith_OUT, RES_CARRY = Carry_OUT.
    - logic: RES_DATA = zero-extended Logic_OUT.
    - compare: RES_DATA = zero-extended CMP_OUT.
    - shift: RES_DATA = zero-extended Shift_OUT.
    - Set RES_VALID and go to OUTPUT.
  - OUTPUT: hold RES_* stable while RES_VALID && !RES_READY. On RES_READY, clear RES_VALID and go to IDLE.
- ALU_A/ALU_B/ALU_FUNC keep their last value outside ISSUE and CAPTURE. The ALU output in those cycles is ignored.
- The FIFO keeps accepting commands while a result is stalled in OUTPUT.

## Timing
- Reset values:
  - State = IDLE, FIFO empty.
  - CMD_READY = 0 while RST is high, 1 after release.
  - ALU_A = 0, ALU_B = 0, ALU_FUNC = 0.
  - RES_VALID = 0, RES_DATA = 0, RES_CARRY = 0, RES_FUNC = 0, ERR = 0.
- Latency: a command accepted at edge k into an empty, idle block is popped at k+1, enters CAPTURE at k+2, and has RES_VALID high after k+3.
- Throughput: at most one result every 4 cycles with RES_READY held high.
- FIFO full: CMD_READY is low in the cycle after the count reaches FIFO_DEPTH. It returns high in the cycle after a pop.
- Reset mid-operation: the in-flight command and all FIFO entries are discarded. All outputs go to their reset values immediately.

## Configuration
- ALU_SEQ_FLAG_CHECK_EN defined:
  - In CAPTURE, the flag of the selected group must be 1 and the other three flags must be 0.
  - Any violation sets ERR, which stays set until RST.
  - The result is still captured and delivered.
- ALU_SEQ_FLAG_CHECK_EN undefined: ERR is tied to 0 and the flag inputs are unused.

## Test plan
- Add: A=0x0003, B=0x0004, FUNC=0000 -> RES_DATA=0x00000007, RES_CARRY=0, RES_FUNC=0000, RES_VALID 3 cycles after acceptance.
- Multiply: A=0xFFFF, B=0xFFFF, FUNC=0010 -> RES_DATA=0xFFFE0001. Then AND: A=0xF0F0, B=0xFF00, FUNC=0100 -> RES_DATA=0x0000F000, RES_CARRY=0.
- Full FIFO: hold RES_READY=0 and push 6 commands with FIFO_DEPTH=4 -> CMD_READY drops after 4 entries are buffered plus 1 in flight. Release RES_READY -> all 5 results arrive in push order with no loss.
- Backpressure: hold RES_READY=0 for 10 cycles -> RES_VALID/RES_DATA are stable throughout, and the handshake completes on the first RES_READY=1.
- Reset mid-operation: assert RST while in ISSUE with 2 entries queued -> RES_VALID=0 and CMD_READY=0 immediately. After release, no stale result appears.
- With ALU_SEQ_FLAG_CHECK_EN, force Logic_Flag=1 during an arith CAPTURE -> ERR=1 and stays 1 until RST. Without the macro, ERR stays 0.
